// File: rtl/bayer_mosaic_streamer.sv
// bayer_mosaic_streamer: turns an RGB pixel stream into a framed Bayer RAW stream.
// Frame: newFrame pulse, SOF_GAP idle cycles, then HEIGHT rows of WIDTH pixels,
// each row followed by HBLANK idle cycles, then a one-cycle oDone pulse.
// Optional feature macro: ISP_MOSAIC_TPG_EN adds iTpg, an internal test pattern source.
module bayer_mosaic_streamer #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int DW      = 8,
  parameter int CFA     = 0,
  parameter int HBLANK  = 16,
  parameter int SOF_GAP = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iStart,
`ifdef ISP_MOSAIC_TPG_EN
  input  logic                      iTpg,
`endif
  input  logic                      iValid,
  input  logic [DW-1:0]             iR,
  input  logic [DW-1:0]             iG,
  input  logic [DW-1:0]             iB,
  output logic                      oReady,
  output logic                      newFrame,
  output logic                      oValid,
  output logic [DW-1:0]             oData,
  output logic [$clog2(WIDTH)-1:0]  oCol,
  output logic [$clog2(HEIGHT)-1:0] oRow,
  output logic                      oDone
);

  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int GMAX = (SOF_GAP > HBLANK) ? SOF_GAP : HBLANK;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  // Phase of each pattern relative to GBRG:
  // GRBG shifts both axes, RGGB shifts rows, BGGR shifts columns.
  localparam logic ROW_FLIP = (CFA == 1) || (CFA == 2);
  localparam logic COL_FLIP = (CFA == 1) || (CFA == 3);

  typedef enum logic [2:0] {IDLE, SOF, GAP, ACTIVE, HBL, DONE} state_t;

  state_t         state, state_nx;
  logic [GW-1:0]  gap_cnt;
  logic [CW-1:0]  col_cnt;
  logic [RW-1:0]  row_cnt;
  logic           frame_end;
  logic           tpg;
  logic           xfer;
  logic           col_last, row_last, sof_gap_end, hbl_end;
  logic [DW-1:0]  src_r, src_g, src_b;

  logic           vld_p1;
  logic [DW-1:0]  data_p1;
  logic [CW-1:0]  col_p1;
  logic [RW-1:0]  row_p1;

  // Pick the one colour sample that the CFA places at (row, col).
  function automatic logic [DW-1:0] mosaic(input logic rp, input logic cp,
                                           input logic [DW-1:0] r,
                                           input logic [DW-1:0] g,
                                           input logic [DW-1:0] b);
    logic [1:0] ph;
    ph = {rp ^ ROW_FLIP, cp ^ COL_FLIP};
    case (ph)
      2'b01:   return b;
      2'b10:   return r;
      default: return g;
    endcase
  endfunction

`ifdef ISP_MOSAIC_TPG_EN
  logic tpg_q;
  // Latch the pattern-generator choice at frame start; it holds for the whole frame.
  always_ff @(posedge clk) begin
    if (reset)                        tpg_q <= 1'b0;
    else if (state == IDLE && iStart) tpg_q <= iTpg;
  end
  assign tpg = tpg_q;
`else
  assign tpg = 1'b0;
`endif

  assign col_last    = (int'(col_cnt) == WIDTH - 1);
  assign row_last    = (int'(row_cnt) == HEIGHT - 1);
  assign sof_gap_end = (int'(gap_cnt) == SOF_GAP - 1);
  assign hbl_end     = (int'(gap_cnt) == HBLANK - 1);
  assign xfer        = (state == ACTIVE) && (tpg || iValid);

  // Next-state and per-state control outputs.
  always_comb begin
    state_nx = state;
    newFrame = 1'b0;
    oDone    = 1'b0;
    oReady   = 1'b0;
    case (state)
      IDLE:   if (iStart) state_nx = SOF;
      SOF: begin
        newFrame = 1'b1;
        state_nx = (SOF_GAP > 0) ? GAP : ACTIVE;
      end
      GAP:    if (sof_gap_end) state_nx = ACTIVE;
      ACTIVE: begin
        oReady = ~tpg;
        if (xfer && col_last) begin
          if (HBLANK > 0)    state_nx = HBL;
          else if (row_last) state_nx = DONE;
        end
      end
      HBL:    if (hbl_end) state_nx = frame_end ? DONE : ACTIVE;
      DONE: begin
        oDone    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Idle-cycle counter for the lead-in gap and horizontal blanking; restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset || state_nx != state) gap_cnt <= '0;
    else if (state == GAP || state == HBL) gap_cnt <= gap_cnt + 1'b1;
  end

  // Pixel position counters; column wraps into the row, rows only clear between frames.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      frame_end <= 1'b0;
    end else if (xfer) begin
      if (col_last) begin
        col_cnt <= '0;
        if (row_last) frame_end <= 1'b1;
        else          row_cnt   <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Pixel source: upstream stream, or the coordinate test pattern.
  always_comb begin
    src_r = iR;
    src_g = iG;
    src_b = iB;
    if (tpg) begin
      src_r = DW'(int'(col_cnt));
      src_g = DW'(int'(row_cnt));
      src_b = DW'(int'(col_cnt) + int'(row_cnt));
    end
  end

  // ---- stage p0 -> p1: one-cycle registered RAW output ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      col_p1  <= '0;
      row_p1  <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= mosaic(row_cnt[0], col_cnt[0], src_r, src_g, src_b);
        col_p1  <= col_cnt;
        row_p1  <= row_cnt;
      end
    end
  end

  assign oValid = vld_p1;
  assign oData  = data_p1;
  assign oCol   = col_p1;
  assign oRow   = row_p1;

endmodule

// File: tb/tb_bayer_mosaic_streamer.sv
// Bench for bayer_mosaic_streamer: two instances (GBRG and BGGR) share one stimulus
// stream; a timeline model predicts handshake/framing and a CFA lookup predicts samples.
module tb_bayer_mosaic_streamer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int SG = 3;

  logic       clk = 1'b0;
  logic       reset, iStart, iValid;
  logic [7:0] iR, iG, iB;
`ifdef ISP_MOSAIC_TPG_EN
  logic       iTpg = 1'b0;
`endif

  logic       rdy0, nf0, v0, dn0, rdy3, nf3, v3, dn3;
  logic [7:0] d0, d3;
  logic [1:0] c0, c3;
  logic [0:0] r0, r3;

  int vectors    = 0;
  int miscompares = 0;

  string      pat[4] = '{"GBRG", "GRBG", "RGGB", "BGGR"};
  logic [7:0] lit0[8] = '{8'h20, 8'h31, 8'h22, 8'h33, 8'h14, 8'h25, 8'h16, 8'h27};
  logic [7:0] lit3[8] = '{8'h30, 8'h21, 8'h32, 8'h23, 8'h24, 8'h15, 8'h26, 8'h17};
  logic [7:0] obs0[$];
  logic [7:0] obs3[$];

  always #5 clk = ~clk;

  bayer_mosaic_streamer #(.WIDTH(W), .HEIGHT(H), .DW(8), .CFA(0), .HBLANK(HB), .SOF_GAP(SG)) u_cfa0 (
    .clk(clk), .reset(reset), .iStart(iStart),
`ifdef ISP_MOSAIC_TPG_EN
    .iTpg(iTpg),
`endif
    .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oReady(rdy0), .newFrame(nf0), .oValid(v0), .oData(d0), .oCol(c0), .oRow(r0), .oDone(dn0));

  bayer_mosaic_streamer #(.WIDTH(W), .HEIGHT(H), .DW(8), .CFA(3), .HBLANK(HB), .SOF_GAP(SG)) u_cfa3 (
    .clk(clk), .reset(reset), .iStart(iStart),
`ifdef ISP_MOSAIC_TPG_EN
    .iTpg(iTpg),
`endif
    .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oReady(rdy3), .newFrame(nf3), .oValid(v3), .oData(d3), .oCol(c3), .oRow(r3), .oDone(dn3));

  // Reference: the colour letter the named CFA pattern puts at (row, col).
  function automatic logic [7:0] expect_sample(input int cfa, input int row, input int col,
                                               input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
    string s;
    byte   ch;
    s  = pat[cfa];
    ch = s[(row % 2) * 2 + (col % 2)];
    if (ch == "R") return r;
    if (ch == "G") return g;
    return b;
  endfunction

  // Run one frame from IDLE (called at a negedge). mode 0: valid=1, ramp data;
  // 1: valid toggles, ramp data; 2: random valid and data. abort_at>=0 resets
  // once that many pixels have been transferred.
  task automatic run_frame(input int mode, input bit pulse_start, input bit hold_start,
                           input int abort_at);
    int c, xfers, idle_left, done_cyc;
    bit prev, tog, rdy_exp;
    int prow, pcol;
    logic [7:0] pr, pg, pb, e0, e3;
    logic [3:0] exp_ctrl;
    c = 0; xfers = 0; idle_left = 1 + SG; done_cyc = -1; prev = 0; tog = 1;
    prow = 0; pcol = 0; pr = 0; pg = 0; pb = 0;
    obs0.delete(); obs3.delete();
    iStart = 1'b1; iValid = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (c > 500) begin
        vectors++; miscompares++;
        $display("FAIL frame_timeout: cycles=%0d required<=500", c);
        iStart = 1'b0;
        break;
      end
      rdy_exp  = (idle_left == 0) && (xfers < W * H);
      exp_ctrl = {c == 1, rdy_exp, prev, c == done_cyc};
      vectors++;
      if ({nf0, rdy0, v0, dn0} !== exp_ctrl) begin
        miscompares++;
        $display("FAIL ctrl_cfa0 cyc=%0d: {nf,rdy,vld,done}=%b required %b", c, {nf0, rdy0, v0, dn0}, exp_ctrl);
      end
      vectors++;
      if ({nf3, rdy3, v3, dn3} !== exp_ctrl) begin
        miscompares++;
        $display("FAIL ctrl_cfa3 cyc=%0d: {nf,rdy,vld,done}=%b required %b", c, {nf3, rdy3, v3, dn3}, exp_ctrl);
      end
      if (prev) begin
        e0 = expect_sample(0, prow, pcol, pr, pg, pb);
        e3 = expect_sample(3, prow, pcol, pr, pg, pb);
        obs0.push_back(d0);
        obs3.push_back(d3);
        vectors++;
        if ({d0, c0, r0} !== {e0, 2'(pcol), 1'(prow)}) begin
          miscompares++;
          $display("FAIL pixel_cfa0 r%0d c%0d: data=%h col=%0d row=%0d required data=%h", prow, pcol, d0, c0, r0, e0);
        end
        vectors++;
        if ({d3, c3, r3} !== {e3, 2'(pcol), 1'(prow)}) begin
          miscompares++;
          $display("FAIL pixel_cfa3 r%0d c%0d: data=%h col=%0d row=%0d required data=%h", prow, pcol, d3, c3, r3, e3);
        end
      end
      if (done_cyc > 0 && c == done_cyc + 1) begin
        iStart = hold_start;
        iValid = 1'b0;
        break;
      end
      if (abort_at >= 0 && xfers == abort_at) begin
        reset = 1'b1; iStart = 1'b0; iValid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({nf0, rdy0, v0, dn0, d0, c0, r0, nf3, rdy3, v3, dn3, d3, c3, r3} !== '0) begin
          miscompares++;
          $display("FAIL abort_outputs: cfa0=%b/%h cfa3=%b/%h required all zero",
                   {nf0, rdy0, v0, dn0}, d0, {nf3, rdy3, v3, dn3}, d3);
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          vectors++;
          if ({nf0, rdy0, v0, dn0, nf3, rdy3, v3, dn3} !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_quiet k=%0d: ctrl=%b required 00000000", k, {nf0, rdy0, v0, dn0, nf3, rdy3, v3, dn3});
          end
        end
        return;
      end
      // drive this cycle's inputs
      if (hold_start)                 iStart = 1'b1;
      else if (pulse_start && c >= 2) iStart = 1'($urandom % 2);
      else                            iStart = 1'b0;
      case (mode)
        0:       iValid = 1'b1;
        1:       begin iValid = tog; tog = ~tog; end
        default: iValid = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) begin
        iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      end else begin
        iR = 8'(8'h10 + xfers); iG = 8'(8'h20 + xfers); iB = 8'(8'h30 + xfers);
      end
      // model: what happens at the coming clock edge
      if (rdy_exp && iValid) begin
        prev = 1; prow = xfers / W; pcol = xfers % W;
        pr = iR; pg = iG; pb = iB;
        xfers++;
        if (xfers % W == 0) begin
          idle_left = HB;
          if (xfers == W * H) done_cyc = c + HB + 1;
        end
      end else begin
        prev = 0;
        if (idle_left > 0) idle_left--;
      end
    end
    if (mode != 2 && abort_at < 0) begin
      vectors++;
      if (obs0.size() != 8 || obs3.size() != 8) begin
        miscompares++;
        $display("FAIL pixel_count: got %0d/%0d required 8", obs0.size(), obs3.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          vectors++;
          if (obs0[i] !== lit0[i] || obs3[i] !== lit3[i]) begin
            miscompares++;
            $display("FAIL literal_seq i=%0d: cfa0=%h cfa3=%h required %h/%h", i, obs0[i], obs3[i], lit0[i], lit3[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; iStart = 1'b0; iValid = 1'b0; iR = '0; iG = '0; iB = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({nf0, rdy0, v0, dn0, d0, c0, r0, nf3, rdy3, v3, dn3, d3, c3, r3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: cfa0=%b/%h cfa3=%b/%h required all zero",
               {nf0, rdy0, v0, dn0}, d0, {nf3, rdy3, v3, dn3}, d3);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_cfa;
    run_frame(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall;
    run_frame(1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_abort;
    run_frame(0, 1'b0, 1'b0, W + 2);
    run_frame(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_ignored;
    run_frame(2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    run_frame(2, 1'b0, 1'b1, -1);
    run_frame(2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    repeat (4) run_frame(2, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_frame_cfa();
    test_stall();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
